// File: rtl/pcmux.sv
// PC mux select encoding shared between hazard_unit, EX and the fetch stage.
package pcmux;

    // pc_plus4: sequential fetch; alu_out: redirect to the EX branch target
    typedef enum logic {
        pc_plus4 = 1'b0,
        alu_out  = 1'b1
    } pcmux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// Common RV32I core types and constants used by the fetch stage.
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

    // FETCH: request outstanding; HOLD: response parked behind a stalled IF/ID;
    // DISCARD: wrong-path request still in flight, its response will be dropped
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32, no alignment check
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_register.sv
// 32-bit register with load enable and asynchronous active-high reset.
// Used for the fetch PC and for the pending redirect target.
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    // Hold the value unless a load is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RESET_VAL;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request/response handshake and the
// IF/ID register. A redirect squashes the wrong-path fetch, including a request
// that is already in flight (DISCARD waits for its response and drops it).
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed.
module fetch_unit
    import rv32i_types::*;
    import pcmux::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  pcmux_sel_t  pcmux_sel,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic        pc_load;
    logic [31:0] tgt_q;
    logic        tgt_load;
    logic [31:0] buf_q;
    logic        buf_load;

    logic        ifid_load;
    logic [31:0] ifid_instr_d;
    logic        drop_resp;

    logic redirect;
    logic consume;
    logic slot_free;

    assign redirect  = (pcmux_sel == alu_out);
    assign consume   = if_valid && !stall;
    assign slot_free = !if_valid || !stall;

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // Latest redirect target seen while a wrong-path request is in flight
    pc_register #(
        .RESET_VAL (32'h0000_0000)
    ) u_tgt_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (tgt_load),
        .d_i    (br_target),
        .q_o    (tgt_q)
    );

    // The address is the PC in every state; in DISCARD the PC still holds the
    // old address so the in-flight request stays stable until its response.
    assign imem_address = pc_q;
    assign imem_read    = !rst && (state_q != HOLD);

    // Next-state, PC/target loads and IF/ID load decision
    always_comb begin
        state_d      = state_q;
        pc_load      = 1'b0;
        pc_d         = pc_inc(pc_q);
        tgt_load     = 1'b0;
        buf_load     = 1'b0;
        ifid_load    = 1'b0;
        ifid_instr_d = imem_rdata;
        drop_resp    = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (imem_resp) begin
                    if (redirect) begin
                        pc_load   = 1'b1;
                        pc_d      = br_target;
                        drop_resp = 1'b1;
                    end else if (slot_free) begin
                        ifid_load = 1'b1;
                        pc_load   = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (redirect) begin
                    tgt_load = 1'b1;
                    state_d  = DISCARD;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_load   = 1'b1;
                    pc_d      = br_target;
                    drop_resp = 1'b1;
                    state_d   = FETCH;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_instr_d = buf_q;
                    pc_load      = 1'b1;
                    state_d      = FETCH;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    tgt_load = 1'b1;
                end
                if (imem_resp) begin
                    drop_resp = 1'b1;
                    pc_load   = 1'b1;
                    pc_d      = redirect ? br_target : tgt_q;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // FSM state, response buffer and IF/ID register; redirect beats stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            buf_q    <= 32'h0000_0000;
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (buf_load) begin
                buf_q <= imem_rdata;
            end
            if (redirect) begin
                if_valid <= 1'b0;
            end else if (ifid_load) begin
                if_valid <= 1'b1;
                if_pc    <= pc_q;
                if_instr <= ifid_instr_d;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [1:0] squash_inc;

    // A redirect can drop a response and invalidate IF/ID in the same cycle
    assign squash_inc = {1'b0, drop_resp} + {1'b0, (redirect && if_valid)};

    // Free-running event counters, wrapping on overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched  <= 32'h0000_0000;
            perf_squashed <= 32'h0000_0000;
        end else begin
            if (ifid_load && !redirect) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_squashed <= perf_squashed + {30'b0, squash_inc};
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined RV32I core. It owns the PC register, drives the instruction-memory request/response handshake and the IF/ID output register. It consumes pcmux_sel and the branch target that hazard_unit and EX produce. On a redirect it squashes the wrong-path fetch, including a request that is already in flight.

Parameters:
- RESET_PC, 32'h0000_0060, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcmux_sel  in  pcmux_sel_t (1)  pc_plus4 = sequential; alu_out = redirect, from hazard_unit.
- br_target  in  32  redirect target from EX; valid when pcmux_sel == alu_out.
- stall  in  1  downstream cannot accept the IF/ID contents this cycle.
- imem_address  out  32  fetch address.
- imem_read  out  1  fetch request.
- imem_rdata  in  32  instruction word.
- imem_resp  in  1  response; may arrive in the same cycle as imem_read.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_pc  out  32  PC of the IF/ID instruction.
- if_instr  out  32  IF/ID instruction word.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; state=FETCH; if_valid=0; if_pc=0; if_instr=0 (NOP encoding 32'h13 is also acceptable; pick 0).
  - imem_read=0 while rst is asserted.
- Memory rule: imem_read and imem_address are held stable from assertion until the imem_resp cycle.
- A consume occurs when if_valid && !stall.
- redirect = (pcmux_sel == alu_out).
  - Redirect has priority over stall.
  - Every redirect clears if_valid at the next edge.
- State FETCH: imem_read=1, imem_address=pc.
  - resp && redirect -> pc<=br_target; data dropped; stay FETCH.
  - resp && slot free (!if_valid || !stall) -> if_pc<=pc, if_instr<=imem_rdata, if_valid<=1, pc<=pc+4; stay FETCH.
  - resp && slot blocked -> buf<=imem_rdata; go HOLD.
  - !resp && redirect -> tgt<=br_target; go DISCARD.
  - Otherwise wait in FETCH.
- State HOLD: imem_read=0.
  - redirect -> pc<=br_target; drop buf; go FETCH.
  - !stall -> IF/ID<={pc, buf}, if_valid<=1, pc<=pc+4; go FETCH.
- State DISCARD: imem_read=1, imem_address=pc (old address stays stable).
  - A new redirect -> tgt<=br_target; the latest target wins.
  - resp -> data dropped; pc<=(redirect ? br_target : tgt); go FETCH.
- Throughput and latency:
  - One instruction per cycle when imem_resp comes back in the same cycle as the request and there is no stall.
  - Fetch-to-if_valid latency is one edge after imem_resp.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0); no alignment check.
- IF/ID holds its value while stalled with no redirect.
- Reset mid-request: the in-flight response is ignored; fetch restarts at RESET_PC.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, count of IF/ID loads) and perf_squashed (32, count of dropped responses plus invalidated IF/ID entries).
  - Both are async-reset to 0 and wrap on overflow.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- fetch_state_t enum {FETCH, HOLD, DISCARD} goes in rv32i_types.
- pcmux_sel_t stays in pcmux.
- RESET_PC default goes in rv32i_types as a localparam.
- One natural sub-module: pc_register (async-reset 32-bit register with load enable), reused for tgt.

Test Plan:
- Reset, then imem_resp tied high, stall=0 -> addresses 0x60, 0x64, 0x68 on consecutive cycles; if_pc follows one cycle later; if_valid=1 from cycle 2.
- stall held 3 cycles with IF/ID full -> IF/ID frozen, a new response is buffered (HOLD), imem_read=0. After release, if_pc increments by 4 with no instruction lost or duplicated.
- Redirect to 0x200 while a request to 0x70 is pending (resp delayed 4 cycles) -> imem_address stays 0x70 until resp, data dropped, next request 0x200, if_valid=0 during the gap.
- Redirect in the same cycle as resp and stall=1 -> if_valid=0 next cycle, next address = br_target.
- Two redirects (0x300 then 0x400) during DISCARD -> the fetch after the response is 0x400.
- rst pulsed mid-request -> outputs reset immediately; first address after release = 0x60. With FETCH_PERF_CNT_EN defined, the counters read 0.
